// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory line port between I-cache and D-cache.
// Optional ARB_ROUND_ROBIN_EN: alternate ties instead of fixed D-cache priority.
module mem_arbiter #(
    parameter int CACHE_LINE_SIZE     = 128,
    parameter int MEMORY_ADDRESS_SIZE = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ic_mem_enable,
    input  logic                           dc_mem_enable,
    input  logic                           ic_mem_op,
    input  logic                           dc_mem_op,
    input  logic                           ic_mem_op_done,
    input  logic                           dc_mem_op_done,
    input  logic [MEMORY_ADDRESS_SIZE-1:0] ic_mem_address,
    input  logic [MEMORY_ADDRESS_SIZE-1:0] dc_mem_address,
    input  logic [CACHE_LINE_SIZE-1:0]     ic_mem_data_in,
    input  logic [CACHE_LINE_SIZE-1:0]     dc_mem_data_in,
    output logic                           ic_mem_data_ready,
    output logic                           dc_mem_data_ready,
    output logic [CACHE_LINE_SIZE-1:0]     ic_mem_data_out,
    output logic [CACHE_LINE_SIZE-1:0]     dc_mem_data_out,
    output logic                           ic_memory_in_use,
    output logic                           dc_memory_in_use,
    output logic                           mem_enable,
    output logic                           mem_op,
    output logic [MEMORY_ADDRESS_SIZE-1:0] mem_address,
    output logic [CACHE_LINE_SIZE-1:0]     mem_data_in,
    input  logic                           mem_data_ready,
    input  logic [CACHE_LINE_SIZE-1:0]     mem_data_out,
    output logic [1:0]                     grant
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        RESPOND  = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [1:0]                     grant_q, grant_d;
    logic                           mem_en_q, mem_en_d;
    logic                           mem_op_q, mem_op_d;
    logic [MEMORY_ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [CACHE_LINE_SIZE-1:0]     mem_din_q, mem_din_d;
    logic                           ic_rdy_q, ic_rdy_d;
    logic                           dc_rdy_q, dc_rdy_d;
    logic [CACHE_LINE_SIZE-1:0]     ic_dout_q, ic_dout_d;
    logic [CACHE_LINE_SIZE-1:0]     dc_dout_q, dc_dout_d;
    logic                           ic_use_q, ic_use_d;
    logic                           dc_use_q, dc_use_d;
    // 1 = D-cache was the last requester served to completion
    logic                           last_dc_q, last_dc_d;

    logic pick_dc;
    logic owner_dc;
    logic owner_en;
    logic owner_done;

`ifdef ARB_ROUND_ROBIN_EN
    assign pick_dc = dc_mem_enable && (!ic_mem_enable || !last_dc_q);
`else
    assign pick_dc = dc_mem_enable;
`endif

    assign owner_dc   = grant_q[1];
    assign owner_en   = owner_dc ? dc_mem_enable  : ic_mem_enable;
    assign owner_done = owner_dc ? dc_mem_op_done : ic_mem_op_done;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        mem_en_d  = mem_en_q;
        mem_op_d  = mem_op_q;
        mem_addr_d = mem_addr_q;
        mem_din_d = mem_din_q;
        ic_rdy_d  = ic_rdy_q;
        dc_rdy_d  = dc_rdy_q;
        ic_dout_d = ic_dout_q;
        dc_dout_d = dc_dout_q;
        ic_use_d  = ic_use_q;
        dc_use_d  = dc_use_q;
        last_dc_d = last_dc_q;

        unique case (state_q)
            IDLE: begin
                if (ic_mem_enable || dc_mem_enable) begin
                    state_d    = WAIT_MEM;
                    grant_d    = pick_dc ? 2'b10 : 2'b01;
                    mem_en_d   = 1'b1;
                    // I-cache never writes memory
                    mem_op_d   = pick_dc ? dc_mem_op : 1'b0;
                    mem_addr_d = pick_dc ? dc_mem_address : ic_mem_address;
                    mem_din_d  = pick_dc ? dc_mem_data_in : ic_mem_data_in;
                    ic_use_d   = pick_dc;
                    dc_use_d   = !pick_dc;
                end
            end
            WAIT_MEM: begin
                if (!owner_en) begin
                    state_d  = IDLE;
                    grant_d  = 2'b00;
                    mem_en_d = 1'b0;
                    ic_use_d = 1'b0;
                    dc_use_d = 1'b0;
                end else if (mem_data_ready) begin
                    state_d  = RESPOND;
                    mem_en_d = 1'b0;
                    if (owner_dc) begin
                        dc_rdy_d = 1'b1;
                        if (!mem_op_q) dc_dout_d = mem_data_out;
                    end else begin
                        ic_rdy_d  = 1'b1;
                        ic_dout_d = mem_data_out;
                    end
                end
            end
            RESPOND: begin
                if (owner_done || !owner_en) begin
                    state_d  = IDLE;
                    grant_d  = 2'b00;
                    ic_rdy_d = 1'b0;
                    dc_rdy_d = 1'b0;
                    ic_use_d = 1'b0;
                    dc_use_d = 1'b0;
                    if (owner_done) last_dc_d = owner_dc;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = 2'b00;
                mem_en_d = 1'b0;
                ic_rdy_d = 1'b0;
                dc_rdy_d = 1'b0;
                ic_use_d = 1'b0;
                dc_use_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            mem_en_q   <= 1'b0;
            mem_op_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            ic_rdy_q   <= 1'b0;
            dc_rdy_q   <= 1'b0;
            ic_dout_q  <= '0;
            dc_dout_q  <= '0;
            ic_use_q   <= 1'b0;
            dc_use_q   <= 1'b0;
            last_dc_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            mem_en_q   <= mem_en_d;
            mem_op_q   <= mem_op_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            ic_rdy_q   <= ic_rdy_d;
            dc_rdy_q   <= dc_rdy_d;
            ic_dout_q  <= ic_dout_d;
            dc_dout_q  <= dc_dout_d;
            ic_use_q   <= ic_use_d;
            dc_use_q   <= dc_use_d;
            last_dc_q  <= last_dc_d;
        end
    end

    assign grant             = grant_q;
    assign mem_enable        = mem_en_q;
    assign mem_op            = mem_op_q;
    assign mem_address       = mem_addr_q;
    assign mem_data_in       = mem_din_q;
    assign ic_mem_data_ready = ic_rdy_q;
    assign dc_mem_data_ready = dc_rdy_q;
    assign ic_mem_data_out   = ic_dout_q;
    assign dc_mem_data_out   = dc_dout_q;
    assign ic_memory_in_use  = ic_use_q;
    assign dc_memory_in_use  = dc_use_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grant and response events checked
// against expectations queued by the directed stimulus.
module tb_mem_arbiter;

    localparam int LW = 128;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_mem_enable, dc_mem_enable;
    logic          ic_mem_op, dc_mem_op;
    logic          ic_mem_op_done, dc_mem_op_done;
    logic [AW-1:0] ic_mem_address, dc_mem_address;
    logic [LW-1:0] ic_mem_data_in, dc_mem_data_in;
    logic          ic_mem_data_ready, dc_mem_data_ready;
    logic [LW-1:0] ic_mem_data_out, dc_mem_data_out;
    logic          ic_memory_in_use, dc_memory_in_use;
    logic          mem_enable, mem_op;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_data_in;
    logic          mem_data_ready;
    logic [LW-1:0] mem_data_out;
    logic [1:0]    grant;

    always #5 clk = ~clk;

    mem_arbiter #(.CACHE_LINE_SIZE(LW), .MEMORY_ADDRESS_SIZE(AW)) dut (
        .clk(clk), .reset(reset),
        .ic_mem_enable(ic_mem_enable), .dc_mem_enable(dc_mem_enable),
        .ic_mem_op(ic_mem_op), .dc_mem_op(dc_mem_op),
        .ic_mem_op_done(ic_mem_op_done), .dc_mem_op_done(dc_mem_op_done),
        .ic_mem_address(ic_mem_address), .dc_mem_address(dc_mem_address),
        .ic_mem_data_in(ic_mem_data_in), .dc_mem_data_in(dc_mem_data_in),
        .ic_mem_data_ready(ic_mem_data_ready), .dc_mem_data_ready(dc_mem_data_ready),
        .ic_mem_data_out(ic_mem_data_out), .dc_mem_data_out(dc_mem_data_out),
        .ic_memory_in_use(ic_memory_in_use), .dc_memory_in_use(dc_memory_in_use),
        .mem_enable(mem_enable), .mem_op(mem_op),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_ready(mem_data_ready), .mem_data_out(mem_data_out),
        .grant(grant)
    );

    typedef struct {
        bit          resp;
        logic [1:0]  who;
        logic        op;
        logic [31:0] addr;
        logic [127:0] data;
        logic        ic_iu;
        logic        dc_iu;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    localparam logic [LW-1:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [LW-1:0] D2 = 128'h1111222233334444555566667777_8888;
    localparam logic [LW-1:0] D3 = 128'h9999AAAABBBBCCCCDDDDEEEEFFFF0000;
    localparam logic [LW-1:0] D4 = 128'hFEEDFACECAFEBEEF0BADF00D12345678;
    localparam logic [LW-1:0] D5 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [LW-1:0] BAD = 128'hDEADDEADDEADDEADDEADDEADDEADDEAD;
    localparam logic [LW-1:0] WA = {32{4'hA}};
    localparam logic [LW-1:0] W5 = {32{4'h5}};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_grant(input logic [1:0] w, input logic op,
                              input logic [31:0] a, input logic [127:0] d);
        exp_t e;
        e.resp = 1'b0; e.who = w; e.op = op; e.addr = a; e.data = d;
        e.ic_iu = w[1]; e.dc_iu = w[0];
        q.push_back(e);
    endtask

    task automatic push_resp(input logic [1:0] w, input logic [127:0] d);
        exp_t e;
        e.resp = 1'b1; e.who = w; e.op = 1'b0; e.addr = '0; e.data = d;
        e.ic_iu = 1'b0; e.dc_iu = 1'b0;
        q.push_back(e);
    endtask

    task automatic serve(input int lat, input logic [127:0] d);
        int n = 0;
        while (!mem_enable && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mem_enable_wait", mem_enable, 1'b1);
        if (mem_enable) begin
            repeat (lat - 1) @(negedge clk);
            mem_data_ready = 1'b1;
            mem_data_out   = d;
            @(negedge clk);
            mem_data_ready = 1'b0;
        end
    endtask

    task automatic finish_req(input bit dc);
        int n = 0;
        while (!(dc ? dc_mem_data_ready : ic_mem_data_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(dc ? "dc_ready_wait" : "ic_ready_wait",
            dc ? dc_mem_data_ready : ic_mem_data_ready, 1'b1);
        if (dc) begin
            dc_mem_op_done = 1'b1; dc_mem_enable = 1'b0;
        end else begin
            ic_mem_op_done = 1'b1; ic_mem_enable = 1'b0;
        end
        @(negedge clk);
        ic_mem_op_done = 1'b0;
        dc_mem_op_done = 1'b0;
    endtask

    task automatic wait_mem_en();
        int n = 0;
        while (!mem_enable && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mem_enable_wait", mem_enable, 1'b1);
    endtask

    // Monitor: grant rising from idle and data_ready rising are scoreboard events
    initial begin
        logic [1:0] pg;
        logic pi, pd;
        exp_t e, cur;
        bit have;
        pg = 2'b00; pi = 1'b0; pd = 1'b0; have = 1'b0;
        forever begin
            @(negedge clk);
            if (grant != 2'b00 && pg == 2'b00) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_grant: got %b want none", grant);
                end else begin
                    e = q.pop_front();
                    chk("grant_event_kind", e.resp, 1'b0);
                    chk("grant", grant, e.who);
                    chk("grant_mem_enable", mem_enable, 1'b1);
                    chk("grant_mem_op", mem_op, e.op);
                    chk("grant_mem_address", mem_address, e.addr);
                    chk("grant_mem_data_in", mem_data_in, e.data);
                    chk("grant_ic_in_use", ic_memory_in_use, e.ic_iu);
                    chk("grant_dc_in_use", dc_memory_in_use, e.dc_iu);
                    cur = e; have = 1'b1;
                end
            end else if (mem_enable && have && grant == cur.who) begin
                chk("hold_mem_op", mem_op, cur.op);
                chk("hold_mem_address", mem_address, cur.addr);
                chk("hold_mem_data_in", mem_data_in, cur.data);
            end
            if ((ic_mem_data_ready && !pi) || (dc_mem_data_ready && !pd)) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ready: got ic=%b dc=%b want none",
                             ic_mem_data_ready, dc_mem_data_ready);
                end else begin
                    e = q.pop_front();
                    chk("resp_event_kind", e.resp, 1'b1);
                    chk("resp_who", {dc_mem_data_ready, ic_mem_data_ready}, e.who);
                    chk("resp_grant", grant, e.who);
                    chk("resp_mem_enable", mem_enable, 1'b0);
                    chk("resp_data", e.who[1] ? dc_mem_data_out : ic_mem_data_out, e.data);
                end
            end
            pg = grant; pi = ic_mem_data_ready; pd = dc_mem_data_ready;
        end
    end

    initial begin
        reset = 1'b0;
        ic_mem_enable = 0; dc_mem_enable = 0; ic_mem_op = 0; dc_mem_op = 0;
        ic_mem_op_done = 0; dc_mem_op_done = 0;
        ic_mem_address = '0; dc_mem_address = '0;
        ic_mem_data_in = '0; dc_mem_data_in = '0;
        mem_data_ready = 0; mem_data_out = '0;
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_mem_enable", mem_enable, 1'b0);
        chk("rst_mem_op", mem_op, 1'b0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_data_in", mem_data_in, 128'h0);
        chk("rst_ready", {ic_mem_data_ready, dc_mem_data_ready}, 2'b00);
        chk("rst_in_use", {ic_memory_in_use, dc_memory_in_use}, 2'b00);
        chk("rst_ic_dout", ic_mem_data_out, 128'h0);
        chk("rst_dc_dout", dc_mem_data_out, 128'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // I-cache alone
        push_grant(2'b01, 1'b0, 32'h40, 128'h0);
        push_resp(2'b01, D1);
        ic_mem_address = 32'h40; ic_mem_enable = 1'b1;
        serve(3, D1);
        finish_req(1'b0);
        chk("ic_done_grant", grant, 2'b00);
        chk("ic_done_in_use", {ic_memory_in_use, dc_memory_in_use}, 2'b00);

        // Simultaneous: D-cache first, I-cache (op=1 forced to read) waits
        push_grant(2'b10, 1'b0, 32'h200, 128'hC2);
        push_resp(2'b10, D2);
        push_grant(2'b01, 1'b0, 32'h80, 128'hC1);
        push_resp(2'b01, D3);
        ic_mem_enable = 1; ic_mem_op = 1; ic_mem_address = 32'h80; ic_mem_data_in = 128'hC1;
        dc_mem_enable = 1; dc_mem_op = 0; dc_mem_address = 32'h200; dc_mem_data_in = 128'hC2;
        serve(2, D2);
        chk("tie_ic_in_use", ic_memory_in_use, 1'b1);
        finish_req(1'b1);
        chk("tie_gap_grant", grant, 2'b00);
        chk("tie_gap_in_use", {ic_memory_in_use, dc_memory_in_use}, 2'b00);
        serve(4, D3);
        finish_req(1'b0);
        ic_mem_op = 0;
        chk("tie_dc_dout_kept", dc_mem_data_out, D2);

        // D-cache write leaves its data_out buffer alone
        push_grant(2'b10, 1'b1, 32'h100, WA);
        push_resp(2'b10, D2);
        dc_mem_enable = 1; dc_mem_op = 1; dc_mem_address = 32'h100; dc_mem_data_in = WA;
        serve(5, W5);
        finish_req(1'b1);
        dc_mem_op = 0;

        // Reset during WAIT_MEM, then re-arbitration of the held request
        push_grant(2'b01, 1'b0, 32'h300, 128'h33);
        ic_mem_enable = 1; ic_mem_address = 32'h300; ic_mem_data_in = 128'h33;
        wait_mem_en();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_mem_enable", mem_enable, 1'b0);
        chk("arst_grant", grant, 2'b00);
        chk("arst_ready", {ic_mem_data_ready, dc_mem_data_ready}, 2'b00);
        chk("arst_in_use", {ic_memory_in_use, dc_memory_in_use}, 2'b00);
        chk("arst_ic_dout", ic_mem_data_out, 128'h0);
        push_grant(2'b01, 1'b0, 32'h300, 128'h33);
        push_resp(2'b01, D4);
        @(negedge clk);
        reset = 1'b1;
        serve(2, D4);
        finish_req(1'b0);

        // Owner aborts in WAIT_MEM; late memory ready in IDLE is ignored
        push_grant(2'b01, 1'b0, 32'h400, 128'h44);
        push_grant(2'b10, 1'b0, 32'h500, 128'h55);
        push_resp(2'b10, D5);
        ic_mem_enable = 1; ic_mem_address = 32'h400; ic_mem_data_in = 128'h44;
        wait_mem_en();
        ic_mem_enable = 0;
        dc_mem_enable = 1; dc_mem_address = 32'h500; dc_mem_data_in = 128'h55;
        @(negedge clk);
        chk("abort_grant", grant, 2'b00);
        chk("abort_mem_enable", mem_enable, 1'b0);
        chk("abort_ic_ready", ic_mem_data_ready, 1'b0);
        mem_data_ready = 1'b1; mem_data_out = BAD;
        @(negedge clk);
        mem_data_ready = 1'b0;
        chk("abort_ic_dout_kept", ic_mem_data_out, D4);
        chk("abort_dc_owner", grant, 2'b10);
        serve(3, D5);
        finish_req(1'b1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
